// File: rtl/home_pkg.sv
// Shared widths, defaults and ADC reader state encodings for the home sensor front end.
package home_pkg;
  localparam int ST_W       = 7;
  localparam int ADC_W      = 8;
  localparam int DEB_CYCLES = 16;
  localparam int NUM_CH     = 4;

  localparam logic [ST_W-1:0] ST_MAX = '1;

  typedef logic [1:0] adc_state_t;
  localparam adc_state_t IDLE = 2'd0;
  localparam adc_state_t CONV = 2'd1;
  localparam adc_state_t LOAD = 2'd2;
endpackage

// File: rtl/sensor_debounce.sv
// One-bit contact debouncer: 2-flop synchronizer followed by a stability counter.
module sensor_debounce #(
  parameter int DEB_CYCLES = home_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Any cycle where the synced level agrees with the output restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/home_sensor_frontend.sv
// Sensor front end: four debounced contacts plus a periodic serial temperature ADC reader.
module home_sensor_frontend #(
  parameter int DEB_CYCLES    = home_pkg::DEB_CYCLES,
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int ADC_W         = home_pkg::ADC_W,
  parameter int ST_W          = home_pkg::ST_W
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            raw_fd,
  input  logic            raw_rd,
  input  logic            raw_w,
  input  logic            raw_fa,
  input  logic            adc_miso,
  output logic            adc_cs_n,
  output logic            adc_sclk,
  output logic            SFD,
  output logic            SRD,
  output logic            SW,
  output logic            SFA,
  output logic [ST_W-1:0] ST,
  output logic            st_valid
);
  import home_pkg::*;

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (ADC_W > 1) ? $clog2(ADC_W) : 1;
  localparam logic [ST_W-1:0] ST_SAT = '1;

  // Contacts as lanes of one debouncer array: {fa, w, rd, fd}.
  logic [NUM_CH-1:0] raw_v, deb_v;
  assign raw_v = {raw_fa, raw_w, raw_rd, raw_fd};

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_CH-1:0] (
    .clk (Clk),
    .rst (Rst),
    .raw (raw_v),
    .deb (deb_v)
  );

  assign SFD = deb_v[0];
  assign SRD = deb_v[1];
  assign SW  = deb_v[2];
  assign SFA = deb_v[3];

  // Free-running sample timer; the wrap cycle is the conversion start request.
  logic [TW-1:0] tmr;
  logic          start_req;
  assign start_req = (tmr == TW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)            tmr <= '0;
    else if (start_req) tmr <= '0;
    else                tmr <= tmr + TW'(1);
  end

  adc_state_t       state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [ADC_W-1:0] shift;
  logic [ST_W-1:0]  st_next;

  assign st_next = (shift > ADC_W'(ST_SAT)) ? ST_SAT : shift[ST_W-1:0];

  // Requests arriving outside IDLE are simply not looked at, so they drop.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      ST       <= '0;
      st_valid <= 1'b0;
    end else begin
      st_valid <= 1'b0;
      case (state)
        IDLE: if (start_req) begin
          adc_cs_n <= 1'b0;
          bit_cnt  <= '0;
          div_cnt  <= '0;
          state    <= CONV;
        end
        CONV: if (div_cnt == DW'(SCLK_DIV - 1)) begin
          div_cnt  <= '0;
          adc_sclk <= ~adc_sclk;
          if (!adc_sclk) begin
            shift <= {shift[ADC_W-2:0], adc_miso};
          end else if (bit_cnt == BW'(ADC_W - 1)) begin
            adc_cs_n <= 1'b1;
            state    <= LOAD;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        LOAD: begin
          ST       <= st_next;
          st_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_home_sensor_frontend.sv
// Directed bench for home_sensor_frontend: debounce timing, ADC read/saturation, mid-conversion reset.
module tb_home_sensor_frontend;
  logic       Clk = 1'b0, Rst = 1'b1;
  logic       raw_fd = 1'b0, raw_rd = 1'b0, raw_w = 1'b0, raw_fa = 1'b0;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n, adc_sclk, SFD, SRD, SW, SFA, st_valid;
  logic [6:0] ST;

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [7:0] adc_word = 8'h3C;
  int   mk = 0;
  logic prev_sclk = 1'b0;

  always #5 Clk = ~Clk;

  home_sensor_frontend dut (
    .Clk(Clk), .Rst(Rst), .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
    .adc_miso(adc_miso), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST), .st_valid(st_valid)
  );

  // Cycles since reset release (first edge after release is 1).
  always @(posedge Clk) begin
    if (Rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  // ADC model: MSB out when CS falls, next bit after each SCLK rise.
  always @(negedge Clk) begin
    if (adc_cs_n) begin
      mk = 0;
      prev_sclk = 1'b0;
    end else begin
      if (adc_sclk && !prev_sclk) mk = mk + 1;
      prev_sclk = adc_sclk;
    end
    adc_miso = (mk < 8) ? adc_word[7 - mk] : 1'b0;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid(input int bound, output bit got);
    got = 1'b0;
    for (int n = 0; n < bound && !got; n++) begin
      tick();
      if (st_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) tick();
    checks++; if ({SFD, SRD, SW, SFA} !== 4'b0000) begin failures++; $display("FAIL reset_deb: got %b want 0000", {SFD, SRD, SW, SFA}); end
    checks++; if (ST !== 7'd0) begin failures++; $display("FAIL reset_st: got %0d want 0", ST); end
    checks++; if (st_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", st_valid); end
    checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b want 0", adc_sclk); end
    Rst = 1'b0;
  endtask

  task automatic test_debounce_fd();
    tick();
    raw_fd = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        checks++; if (SFD !== 1'b0) begin failures++; $display("FAIL fd_early: SFD=%b want 0 at cycle 17", SFD); end
      end
      if (k == 18) begin
        checks++; if (SFD !== 1'b1) begin failures++; $display("FAIL fd_rise: SFD=%b want 1 at cycle 18", SFD); end
      end
    end
    checks++; if ({SRD, SW, SFA} !== 3'b000) begin failures++; $display("FAIL fd_others: got %b want 000", {SRD, SW, SFA}); end
    repeat (12) tick();
    checks++; if (SFD !== 1'b1) begin failures++; $display("FAIL fd_hold: SFD=%b want 1", SFD); end
  endtask

  task automatic test_debounce_glitch();
    bit changed = 1'b0;
    for (int p = 0; p < 10; p++) begin
      raw_w = (p % 2 == 0);
      repeat (10) begin
        tick();
        if (SW !== 1'b0) changed = 1'b1;
      end
    end
    checks++; if (changed !== 1'b0) begin failures++; $display("FAIL w_glitch: SW moved=%b want 0", changed); end
    raw_w = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        checks++; if (SW !== 1'b0) begin failures++; $display("FAIL w_early: SW=%b want 0", SW); end
      end
      if (k == 18) begin
        checks++; if (SW !== 1'b1) begin failures++; $display("FAIL w_rise: SW=%b want 1", SW); end
      end
    end
    raw_fd = 1'b0;
    raw_w  = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        checks++; if ({SFD, SW} !== 2'b11) begin failures++; $display("FAIL fall_early: {SFD,SW}=%b want 11", {SFD, SW}); end
      end
      if (k == 18) begin
        checks++; if ({SFD, SW} !== 2'b00) begin failures++; $display("FAIL fall: {SFD,SW}=%b want 00", {SFD, SW}); end
      end
    end
  endtask

  task automatic test_all_contacts();
    tick();
    {raw_fa, raw_w, raw_rd, raw_fd} = 4'hF;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        checks++; if ({SFD, SRD, SW, SFA} !== 4'b0000) begin failures++; $display("FAIL all_early: got %b want 0000", {SFD, SRD, SW, SFA}); end
      end
      if (k == 18) begin
        checks++; if ({SFD, SRD, SW, SFA} !== 4'b1111) begin failures++; $display("FAIL all_rise: got %b want 1111", {SFD, SRD, SW, SFA}); end
      end
    end
  endtask

  task automatic test_adc_basic();
    int   cs_low = 0, rises = 0;
    logic ps = 1'b0;
    bit   got = 1'b0;
    adc_word = 8'h3C;
    for (int n = 0; n < 1500 && !got; n++) begin
      tick();
      if (adc_cs_n === 1'b0) cs_low++;
      if (adc_sclk === 1'b1 && !ps) rises++;
      ps = adc_sclk;
      if (st_valid === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL adc_timeout: no st_valid within 1500 cycles"); end
    checks++; if (cyc != 1065) begin failures++; $display("FAIL adc_latency: st_valid at cycle %0d want 1065", cyc); end
    checks++; if (ST !== 7'd60) begin failures++; $display("FAIL adc_value: ST=%0d want 60", ST); end
    checks++; if (cs_low != 64) begin failures++; $display("FAIL adc_cs_window: cs_n low %0d cycles want 64", cs_low); end
    checks++; if (rises != 8) begin failures++; $display("FAIL adc_sclk_count: %0d rising edges want 8", rises); end
    tick();
    checks++; if (st_valid !== 1'b0) begin failures++; $display("FAIL adc_pulse: st_valid=%b want 0 one cycle later", st_valid); end
    checks++; if (ST !== 7'd60) begin failures++; $display("FAIL adc_hold: ST=%0d want 60", ST); end
  endtask

  task automatic test_saturation();
    bit got;
    adc_word = 8'd200;
    wait_valid(1200, got);
    checks++; if (!got) begin failures++; $display("FAIL sat_timeout: no st_valid"); end
    checks++; if (ST !== 7'd127) begin failures++; $display("FAIL sat_value: ST=%0d want 127", ST); end
    checks++; if (cyc != 2065) begin failures++; $display("FAIL sat_period: st_valid at cycle %0d want 2065", cyc); end
    adc_word = 8'd20;
    wait_valid(1200, got);
    checks++; if (!got) begin failures++; $display("FAIL small_timeout: no st_valid"); end
    checks++; if (ST !== 7'd20) begin failures++; $display("FAIL small_value: ST=%0d want 20", ST); end
    checks++; if (cyc != 3065) begin failures++; $display("FAIL small_period: st_valid at cycle %0d want 3065", cyc); end
  endtask

  task automatic test_reset_mid_conv();
    bit   got = 1'b0, st_moved = 1'b0;
    int   rises = 0;
    logic ps = 1'b0;
    adc_word = 8'h55;
    for (int n = 0; n < 1200 && adc_cs_n !== 1'b0; n++) tick();
    checks++; if (adc_cs_n !== 1'b0) begin failures++; $display("FAIL mid_cs_timeout: cs_n=%b want 0", adc_cs_n); end
    for (int n = 0; n < 100 && rises < 3; n++) begin
      tick();
      if (adc_sclk === 1'b1 && !ps) rises++;
      ps = adc_sclk;
    end
    checks++; if (rises != 3) begin failures++; $display("FAIL mid_rises: saw %0d rising edges want 3", rises); end
    #2 Rst = 1'b1;
    #1;
    checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("FAIL mid_cs_n: got %b want 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b0) begin failures++; $display("FAIL mid_sclk: got %b want 0", adc_sclk); end
    checks++; if (ST !== 7'd0) begin failures++; $display("FAIL mid_st: ST=%0d want 0", ST); end
    checks++; if ({SFD, SRD, SW, SFA} !== 4'b0000) begin failures++; $display("FAIL mid_deb: got %b want 0000", {SFD, SRD, SW, SFA}); end
    tick();
    tick();
    Rst = 1'b0;
    for (int n = 0; n < 1200 && !got; n++) begin
      tick();
      if (st_valid === 1'b1) got = 1'b1;
      else if (ST !== 7'd0) st_moved = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL mid_timeout: no st_valid after reset"); end
    checks++; if (st_moved) begin failures++; $display("FAIL mid_st_hold: ST changed before next conversion"); end
    checks++; if (cyc != 1065) begin failures++; $display("FAIL mid_latency: st_valid at cycle %0d want 1065", cyc); end
    checks++; if (ST !== 7'd85) begin failures++; $display("FAIL mid_value: ST=%0d want 85", ST); end
  endtask

  initial begin
    test_reset();
    test_debounce_fd();
    test_debounce_glitch();
    test_all_contacts();
    test_adc_basic();
    test_saturation();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
